// File: rtl/seg_auto_counter_mux_pkg.sv
// Shared constants for the segment display blocks: digit width, digit maxima and
// the a..g active-high decode patterns.
`default_nettype none

package seg_auto_counter_mux_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_BCD = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_HEX = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [DIGIT_W-1:0] digit_max(input bit hex_mode);
    return hex_mode ? MAX_HEX : MAX_BCD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_auto_counter_mux_seg7_decode.sv
// seg7_decode: combinational nibble to 7-segment pattern (seg[0]=a .. seg[6]=g).
`default_nettype none

module seg7_decode
  import seg_auto_counter_mux_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_auto_counter_mux.sv
// seg_auto_counter_mux: N-digit BCD/hex up/down counter with multiplexed 7-segment scan.
// Optional SEG_LEAD_BLANK_EN blanks leading zero digits (digit 0 never blanked).
`default_nettype none

module seg_auto_counter_mux
  import seg_auto_counter_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int HEX_MODE   = 0,
  parameter int TICK_DIV   = 250000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp,
  output logic                          wrap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count
);

  localparam int CW = DIGIT_W * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIGIT_W-1:0] DMAX = digit_max(HEX_MODE != 0);

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  w_tick;
  logic                  w_scan_wrap;
  logic [CW-1:0]         w_step;
  logic                  w_step_carry;
  logic [CW-1:0]         w_load_sat;
  logic [DIGIT_W-1:0]    w_cur_digit;
  logic [6:0]            w_dec_seg;
  logic                  w_blank;

  assign w_tick = en && (tick_cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (load || w_tick) begin
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Ripple carry/borrow through the digit chain; carry out of the top digit is the wrap.
  always_comb begin : p_step
    logic [DIGIT_W-1:0] d;
    logic               c;
    d      = '0;
    c      = 1'b1;
    w_step = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count_q[DIGIT_W*i +: DIGIT_W];
      if (c) begin
        if (up_dn) begin
          if (d == DMAX) begin
            w_step[DIGIT_W*i +: DIGIT_W] = '0;
          end else begin
            w_step[DIGIT_W*i +: DIGIT_W] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_step[DIGIT_W*i +: DIGIT_W] = DMAX;
          end else begin
            w_step[DIGIT_W*i +: DIGIT_W] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    w_step_carry = c;
  end

  always_comb begin
    w_load_sat = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[DIGIT_W*i +: DIGIT_W] > DMAX) begin
        w_load_sat[DIGIT_W*i +: DIGIT_W] = DMAX;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = w_load_sat;
    end else if (w_tick) begin
      count_d = w_step;
      wrap_d  = w_step_carry;
    end
  end

  assign w_scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));

  always_comb begin
    scan_cnt_d = w_scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (w_scan_wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    w_cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_cur_digit = count_q[DIGIT_W*i +: DIGIT_W];
      end
    end
  end

`ifdef SEG_LEAD_BLANK_EN
  always_comb begin : p_blank
    logic zero_above;
    zero_above = 1'b1;
    w_blank    = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (count_q[DIGIT_W*i +: DIGIT_W] == 4'd0);
      if (idx_q == IW'(i)) begin
        w_blank = zero_above;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  seg7_decode u_seg7_decode (
    .nibble_i (w_cur_digit),
    .seg_o    (w_dec_seg)
  );

  assign an_d  = NUM_DIGITS'(1) << idx_q;
  assign seg_d = w_blank ? SEG_BLANK : w_dec_seg;
  assign dp_d  = ~en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      an_q       <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign wrap  = wrap_q;
  assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_auto_counter_mux.sv
// Scoreboard bench for seg_auto_counter_mux: a BCD and a hex instance share stimulus.
`default_nettype none

module tb_seg_auto_counter_mux;

  localparam int S_CNT = 0, S_AN = 1, S_SEG = 2, S_DP = 3, S_WRAP = 4;
  localparam int S_HCNT = 5, S_HWRAP = 6, S_HAN = 7, S_HSEG = 8, S_HDP = 9;

`ifdef SEG_LEAD_BLANK_EN
  localparam logic [7:0] LEAD0_SEG = 8'h00;
`else
  localparam logic [7:0] LEAD0_SEG = 8'h3F;
`endif

  logic       clk, rst, en, up_dn, load;
  logic [7:0] load_val;
  logic [6:0] seg, h_seg;
  logic [1:0] an, h_an;
  logic       dp, h_dp, wrap, h_wrap;
  logic [7:0] count, h_count;

  seg_auto_counter_mux #(.NUM_DIGITS(2), .HEX_MODE(0), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .seg(seg), .an(an), .dp(dp), .wrap(wrap), .count(count)
  );

  seg_auto_counter_mux #(.NUM_DIGITS(2), .HEX_MODE(1), .TICK_DIV(4), .SCAN_DIV(2)) dut_hex (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .seg(h_seg), .an(h_an), .dp(h_dp), .wrap(h_wrap), .count(h_count)
  );

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   r_rel = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int sel);
    case (sel)
      S_CNT:   return count;
      S_AN:    return {6'b0, an};
      S_SEG:   return {1'b0, seg};
      S_DP:    return {7'b0, dp};
      S_WRAP:  return {7'b0, wrap};
      S_HCNT:  return h_count;
      S_HWRAP: return {7'b0, h_wrap};
      S_HAN:   return {6'b0, h_an};
      S_HSEG:  return {1'b0, h_seg};
      S_HDP:   return {7'b0, h_dp};
      default: return 8'hxx;
    endcase
  endfunction

  // Scan position model: after reset release at r_rel, each digit holds for 2 cycles.
  function automatic logic [7:0] an_exp(input int c);
    return ((((c - r_rel - 1) / 2) % 2) == 0) ? 8'h01 : 8'h02;
  endfunction

  task automatic expect_at(input int dc, input int sel, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every scoreboard entry due in the current cycle.
  always @(negedge clk) begin
    int         i;
    logic [7:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = sample(sb[i].sel);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed at cyc=%0d", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    step(3);
    expect_at(0, S_CNT,  8'h00, "rst_count");
    expect_at(0, S_AN,   8'h00, "rst_an");
    expect_at(0, S_SEG,  8'h00, "rst_seg");
    expect_at(0, S_DP,   8'h00, "rst_dp");
    expect_at(0, S_WRAP, 8'h00, "rst_wrap");
    step(1);

    // Free-running count and scan after release
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; r_rel = cyc;
    expect_at(3, S_CNT, 8'h00, "t1_count_pre");
    expect_at(4, S_CNT, 8'h01, "t1_count_4");
    expect_at(7, S_CNT, 8'h01, "t1_count_hold");
    expect_at(8, S_CNT, 8'h02, "t1_count_8");
    for (int k = 1; k <= 5; k++) expect_at(k, S_AN, an_exp(cyc + k), "t1_an");
    expect_at(1, S_SEG, 8'h3F, "t1_seg_d0");
    expect_at(3, S_SEG, LEAD0_SEG, "t1_seg_d1");
    expect_at(5, S_SEG, 8'h06, "t1_seg_1");
    expect_at(1, S_DP,  8'h00, "t1_dp");
    step(8);

    // Load 99, wrap up, then wrap down
    load = 1'b1; load_val = 8'h99;
    expect_at(1,  S_CNT,  8'h99, "t2_load99");
    expect_at(4,  S_CNT,  8'h99, "t2_pre_tick");
    expect_at(4,  S_WRAP, 8'h00, "t2_wrap_pre");
    expect_at(5,  S_CNT,  8'h00, "t2_up_wrap");
    expect_at(5,  S_WRAP, 8'h01, "t2_wrap_up");
    expect_at(6,  S_WRAP, 8'h00, "t2_wrap_once");
    expect_at(8,  S_CNT,  8'h00, "t2_pre_down");
    expect_at(9,  S_CNT,  8'h99, "t2_down_wrap");
    expect_at(9,  S_WRAP, 8'h01, "t2_wrap_down");
    expect_at(10, S_WRAP, 8'h00, "t2_wrap_once2");
    step(1);
    load = 1'b0;
    step(4);
    up_dn = 1'b0;
    step(5);
    up_dn = 1'b1;

    // Saturating BCD load versus hex load and hex wrap
    load = 1'b1; load_val = 8'hAB;
    expect_at(1, S_CNT,   8'h99, "t3_bcd_sat");
    expect_at(1, S_HCNT,  8'hAB, "t3_hex_ab");
    expect_at(2, S_CNT,   8'h99, "t3_bcd_ff");
    expect_at(2, S_HCNT,  8'hFF, "t3_hex_ff");
    expect_at(6, S_HCNT,  8'h00, "t3_hex_wrap_cnt");
    expect_at(6, S_HWRAP, 8'h01, "t3_hex_wrap");
    expect_at(7, S_HWRAP, 8'h00, "t3_hex_wrap_once");
    expect_at(6, S_CNT,   8'h00, "t3_bcd_wrap_cnt");
    expect_at(6, S_WRAP,  8'h01, "t3_bcd_wrap");
    step(1);
    load_val = 8'hFF;
    step(1);
    load = 1'b0;
    step(6);

    // Pause: frozen count, dp set, scan keeps running
    load = 1'b1; load_val = 8'h37;
    expect_at(1,  S_CNT, 8'h37, "t4_load37");
    expect_at(1,  S_DP,  8'h00, "t4_dp_run");
    expect_at(2,  S_DP,  8'h01, "t4_dp_pause");
    for (int k = 5; k <= 8; k++) expect_at(k, S_AN, an_exp(cyc + k), "t4_an_scan");
    expect_at(21, S_CNT, 8'h37, "t4_frozen");
    expect_at(21, S_DP,  8'h01, "t4_dp_end");
    expect_at(22, S_DP,  8'h00, "t4_dp_resume");
    expect_at(24, S_CNT, 8'h37, "t4_not_early");
    expect_at(25, S_CNT, 8'h38, "t4_step");
    step(1);
    load = 1'b0; en = 1'b0;
    step(20);
    en = 1'b1;
    step(4);

    // Load coincident with a tick that would otherwise wrap
    load = 1'b1; load_val = 8'h99;
    expect_at(1, S_CNT, 8'h99, "t5_load99");
    step(1);
    load = 1'b0;
    step(3);
    load = 1'b1; load_val = 8'h42;
    expect_at(1, S_CNT,  8'h42, "t5_load_prio");
    expect_at(1, S_WRAP, 8'h00, "t5_no_wrap");
    expect_at(2, S_WRAP, 8'h00, "t5_no_wrap2");
    expect_at(4, S_CNT,  8'h42, "t5_restart_hold");
    expect_at(5, S_CNT,  8'h43, "t5_restart_step");
    step(1);
    load = 1'b0;
    step(4);

    // Asynchronous reset while digit 1 is selected
    for (int k = 0; k < 4 && (((cyc - r_rel - 1) % 4) != 2); k++) step(1);
    expect_at(0, S_AN, 8'h02, "t6_an_before");
    step(1);
    rst = 1'b1;
    expect_at(0, S_CNT,  8'h00, "t6_async_count");
    expect_at(0, S_AN,   8'h00, "t6_async_an");
    expect_at(0, S_SEG,  8'h00, "t6_async_seg");
    expect_at(0, S_WRAP, 8'h00, "t6_async_wrap");
    expect_at(0, S_HCNT, 8'h00, "t6_async_hcount");
    step(2);

    // Leading-zero display of 05
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h05; r_rel = cyc;
    expect_at(1, S_CNT, 8'h05, "t7_load05");
    expect_at(1, S_SEG, 8'h3F, "t7_seg_first");
    expect_at(2, S_AN,  8'h01, "t7_an_d0");
    expect_at(2, S_SEG, 8'h6D, "t7_seg_5");
    expect_at(3, S_AN,  8'h02, "t7_an_d1");
    expect_at(3, S_SEG, LEAD0_SEG, "t7_seg_lead");
    expect_at(5, S_AN,  8'h01, "t7_an_back");
    expect_at(5, S_SEG, 8'h6D, "t7_seg_5b");
    step(1);
    load = 1'b0;
    step(5);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (cyc=%0d)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
